// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types and defaults for the parking entry controller
// Contents:
//   state_t        one-hot FSM state encoding (7 states)
//   ST_*_B         bit positions of each state inside state_t
//   DEF_PIN_W      default PIN bus width
//   DEF_PIN_VALUE  default accepted PIN
package parking_pkg;

  localparam int unsigned DEF_PIN_W     = 8;
  localparam int unsigned DEF_PIN_VALUE = 72;
  localparam int unsigned ST_W          = 7;

  localparam int unsigned ST_IDLE_B      = 0;
  localparam int unsigned ST_WAIT_PIN_B  = 1;
  localparam int unsigned ST_BAD_PIN_B   = 2;
  localparam int unsigned ST_PIN_ALARM_B = 3;
  localparam int unsigned ST_ENTERING_B  = 4;
  localparam int unsigned ST_CLOSING_B   = 5;
  localparam int unsigned ST_BLOCKED_B   = 6;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE      = 7'b000_0001,
    ST_WAIT_PIN  = 7'b000_0010,
    ST_BAD_PIN   = 7'b000_0100,
    ST_PIN_ALARM = 7'b000_1000,
    ST_ENTERING  = 7'b001_0000,
    ST_CLOSING   = 7'b010_0000,
    ST_BLOCKED   = 7'b100_0000
  } state_t;

endpackage

// File: rtl/parking_gate_ctrl_p_if.sv
// rtl/parking_gate_ctrl_p_if.sv - strobed keypad PIN bus
// Signals:
//   pin        PIN_W  keypad PIN, meaningful only while pin_valid=1
//   pin_valid  1      one-cycle strobe, PIN entry complete
// Modports: master (keypad side, drives), slave (controller side, samples)
interface parking_gate_ctrl_p_if
  import parking_pkg::*;
#(
  parameter int unsigned PIN_W = DEF_PIN_W
);

  logic [PIN_W-1:0] pin;
  logic             pin_valid;

  modport master (output pin, output pin_valid);
  modport slave  (input  pin, input  pin_valid);

endinterface

// File: rtl/parking_occ_counter.sv
// rtl/parking_occ_counter.sv - saturating lot-occupancy up/down counter
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   inc           one car entered the lot this cycle
//   dec           one car left the lot this cycle
//   occupancy     cars in lot, saturates at 0 and CAPACITY
//   full          registered (occupancy == CAPACITY), one cycle behind occupancy
module parking_occ_counter
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY = 16,
  parameter int unsigned OCC_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [OCC_W-1:0] occupancy,
  output logic             full
);

  localparam logic [OCC_W-1:0] CAP_V = OCC_W'(CAPACITY);

  always_ff @(posedge clock) begin
    if (reset) begin
      occupancy <= '0;
      full      <= 1'b0;
    end else begin
      // full samples the pre-update count, hence the one-cycle lag
      full <= (occupancy == CAP_V);
      // a simultaneous entry and exit cancel out
      if (inc && !dec && (occupancy != CAP_V)) begin
        occupancy <= occupancy + 1'b1;
      end else if (dec && !inc && (occupancy != '0)) begin
        occupancy <= occupancy - 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_gate_ctrl_p.sv
// rtl/parking_gate_ctrl_p.sv - single-lane parking entry gate controller
// Optional feature macro: PARKING_ALM_STATS_EN (adds alm_count)
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   pin_if        keypad PIN bus (slave): pin, pin_valid
//   senr_e        vehicle at entry sensor
//   senr_x        vehicle fully past gate
//   senr_out      one-cycle pulse, vehicle left via exit lane
//   gate_o        open gate
//   gate_cls      close gate, one-cycle pulse
//   alm_pin       wrong-PIN alarm
//   alm_blkg      gate-blocking alarm
//   lot_full      occupancy == CAPACITY (registered)
//   occupancy     cars in lot
//   tries_left    remaining PIN attempts before alarm
//   alm_count     [PARKING_ALM_STATS_EN] saturating count of alarm-state entries
module parking_gate_ctrl_p
  import parking_pkg::*;
#(
  parameter int unsigned      PIN_W        = DEF_PIN_W,
  parameter logic [PIN_W-1:0] PIN_VALUE    = PIN_W'(DEF_PIN_VALUE),
  parameter int unsigned      MAX_TRIES    = 3,
  parameter int unsigned      CAPACITY     = 16,
  parameter int unsigned      GATE_TIMEOUT = 1000,
  parameter int unsigned      OCC_W        = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  parking_gate_ctrl_p_if.slave   pin_if,
  input  logic                   senr_e,
  input  logic                   senr_x,
  input  logic                   senr_out,
  output logic                   gate_o,
  output logic                   gate_cls,
  output logic                   alm_pin,
  output logic                   alm_blkg,
  output logic                   lot_full,
  output logic [OCC_W-1:0]       occupancy,
  output logic [3:0]             tries_left
`ifdef PARKING_ALM_STATS_EN
  ,
  output logic [15:0]            alm_count
`endif
);

  localparam logic [3:0]       MAX_V    = 4'(MAX_TRIES);
  localparam int unsigned      TMO_W    = $clog2(GATE_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GATE_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [3:0]       attempts;
  logic [TMO_W-1:0] tmo_cnt;
  logic             occ_inc;
  logic             pin_ok;
  logic             pin_wrong;

  assign pin_ok    = pin_if.pin_valid && (pin_if.pin == PIN_VALUE);
  assign pin_wrong = pin_if.pin_valid && (pin_if.pin != PIN_VALUE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    occ_inc    = 1'b0;
    gate_o     = 1'b0;
    gate_cls   = 1'b0;
    alm_pin    = 1'b0;
    alm_blkg   = 1'b0;
    tries_left = MAX_V - attempts;
    unique case (state)
      ST_IDLE: begin
        if (senr_e && !lot_full) state_nxt = ST_WAIT_PIN;
      end
      ST_WAIT_PIN, ST_BAD_PIN: begin
        if (pin_ok) begin
          state_nxt = ST_ENTERING;
        end else if (pin_wrong) begin
          state_nxt = (attempts + 4'd1 == MAX_V) ? ST_PIN_ALARM : ST_BAD_PIN;
        end
      end
      ST_PIN_ALARM: begin
        alm_pin    = 1'b1;
        tries_left = 4'd0;
        if (pin_ok) state_nxt = ST_ENTERING;
      end
      ST_ENTERING: begin
        gate_o = 1'b1;
        // a car on both sensors at once means something is under the gate
        if (senr_e && senr_x) begin
          state_nxt = ST_BLOCKED;
        end else if (senr_x) begin
          state_nxt = ST_CLOSING;
          occ_inc   = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ST_CLOSING;
        end
      end
      ST_BLOCKED: begin
        gate_o   = 1'b1;
        alm_blkg = 1'b1;
        // the car is counted when the attendant releases the gate
        if (pin_ok) begin
          state_nxt = ST_CLOSING;
          occ_inc   = 1'b1;
        end
      end
      ST_CLOSING: begin
        gate_cls  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Attempts only grow in WAIT_PIN/BAD_PIN, so they can never pass MAX_TRIES;
  // they are cleared on the edge into ENTERING so tries_left reads full there.
  always_ff @(posedge clock) begin
    if (reset) begin
      attempts <= 4'd0;
    end else if (state_nxt == ST_ENTERING && state != ST_ENTERING) begin
      attempts <= 4'd0;
    end else if ((state == ST_WAIT_PIN || state == ST_BAD_PIN) && pin_wrong) begin
      attempts <= attempts + 4'd1;
    end
  end

  // Reads 0 on the first ENTERING cycle and n-1 on the n-th.
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state == ST_ENTERING) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  parking_occ_counter #(
    .CAPACITY (CAPACITY),
    .OCC_W    (OCC_W)
  ) u_occ (
    .clock     (clock),
    .reset     (reset),
    .inc       (occ_inc),
    .dec       (senr_out),
    .occupancy (occupancy),
    .full      (lot_full)
  );

`ifdef PARKING_ALM_STATS_EN
  logic alm_enter;

  assign alm_enter = ((state_nxt == ST_PIN_ALARM) && (state != ST_PIN_ALARM)) ||
                     ((state_nxt == ST_BLOCKED)   && (state != ST_BLOCKED));

  always_ff @(posedge clock) begin
    if (reset) begin
      alm_count <= 16'd0;
    end else if (alm_enter && (alm_count != 16'hFFFF)) begin
      alm_count <= alm_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parking_gate_ctrl_p.sv
// tb/tb_parking_gate_ctrl_p.sv - scoreboard bench for parking_gate_ctrl_p
module tb_parking_gate_ctrl_p;

  localparam int PW  = 8;
  localparam int PV  = 72;
  localparam int MT  = 3;
  localparam int CAP = 4;
  localparam int TMO = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic       senr_e, senr_x, senr_out;
  logic       gate_o, gate_cls, alm_pin, alm_blkg, lot_full;
  logic [7:0] occupancy;
  logic [3:0] tries_left;
`ifdef PARKING_ALM_STATS_EN
  logic [15:0] alm_count;
`endif

  parking_gate_ctrl_p_if #(.PIN_W(PW)) pin_if ();

  always #5 clock = ~clock;

  parking_gate_ctrl_p #(
    .PIN_W        (PW),
    .PIN_VALUE    (8'd72),
    .MAX_TRIES    (MT),
    .CAPACITY     (CAP),
    .GATE_TIMEOUT (TMO),
    .OCC_W        (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pin_if     (pin_if.slave),
    .senr_e     (senr_e),
    .senr_x     (senr_x),
    .senr_out   (senr_out),
    .gate_o     (gate_o),
    .gate_cls   (gate_cls),
    .alm_pin    (alm_pin),
    .alm_blkg   (alm_blkg),
    .lot_full   (lot_full),
    .occupancy  (occupancy),
    .tries_left (tries_left)
`ifdef PARKING_ALM_STATS_EN
    ,
    .alm_count  (alm_count)
`endif
  );

  typedef struct packed {
    logic        gate_o;
    logic        gate_cls;
    logic        alm_pin;
    logic        alm_blkg;
    logic        lot_full;
    logic [7:0]  occ;
    logic [3:0]  tries;
    logic [15:0] acnt;
  } snap_t;

  snap_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  // Reference model: phases of a car's visit, counted in plain integers.
  typedef enum {AT_REST, ASKING, RETRYING, ALARMED, DRIVING_IN, STUCK, SHUTTING} phase_t;
  phase_t ph = AT_REST;
  int     att = 0, in_gate = 0, cars = 0, alarms = 0;
  bit     full_flag = 0;

  task automatic model_step(input bit r, e, x, o, pv, input int p);
    phase_t nx;
    bit good, car_in;
    if (r) begin
      ph = AT_REST; att = 0; in_gate = 0; cars = 0; full_flag = 0; alarms = 0;
      return;
    end
    good   = pv && (p == PV);
    car_in = 0;
    nx     = ph;
    case (ph)
      AT_REST:    if (e && !full_flag) nx = ASKING;
      ASKING, RETRYING:
        if (good) nx = DRIVING_IN;
        else if (pv) begin
          att = att + 1;
          nx  = (att >= MT) ? ALARMED : RETRYING;
        end
      ALARMED:    if (good) nx = DRIVING_IN;
      DRIVING_IN:
        if (e && x) nx = STUCK;
        else if (x) begin nx = SHUTTING; car_in = 1; end
        else if (in_gate + 1 == TMO) nx = SHUTTING;
      STUCK:      if (good) begin nx = SHUTTING; car_in = 1; end
      SHUTTING:   nx = AT_REST;
      default:    nx = AT_REST;
    endcase
    full_flag = (cars == CAP);
    if (car_in && !o && cars < CAP) cars = cars + 1;
    else if (o && !car_in && cars > 0) cars = cars - 1;
    if (nx == DRIVING_IN && ph != DRIVING_IN) att = 0;
    in_gate = (nx == DRIVING_IN && ph == DRIVING_IN) ? in_gate + 1 : 0;
    if ((nx == ALARMED || nx == STUCK) && nx != ph && alarms < 65535) alarms = alarms + 1;
    ph = nx;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.gate_o   = (ph == DRIVING_IN) || (ph == STUCK);
    s.gate_cls = (ph == SHUTTING);
    s.alm_pin  = (ph == ALARMED);
    s.alm_blkg = (ph == STUCK);
    s.lot_full = full_flag;
    s.occ      = 8'(cars);
    s.tries    = (ph == ALARMED) ? 4'd0 : 4'(MT - att);
`ifdef PARKING_ALM_STATS_EN
    s.acnt     = 16'(alarms);
`else
    s.acnt     = 16'd0;
`endif
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("gate_o=%0b gate_cls=%0b alm_pin=%0b alm_blkg=%0b lot_full=%0b occ=%0d tries=%0d acnt=%0d",
                     s.gate_o, s.gate_cls, s.alm_pin, s.alm_blkg, s.lot_full, s.occ, s.tries, s.acnt);
  endfunction

  // Stimulus side: the model sees the same inputs as the DUT at each edge.
  always @(posedge clock) begin
    model_step(reset, senr_e, senr_x, senr_out, pin_if.pin_valid, int'(pin_if.pin));
    exp_q.push_back(model_snap());
  end

  // Checking side: compare whatever the DUT shows against the oldest expectation.
  initial begin
    snap_t e, a;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.gate_o   = gate_o;
        a.gate_cls = gate_cls;
        a.alm_pin  = alm_pin;
        a.alm_blkg = alm_blkg;
        a.lot_full = lot_full;
        a.occ      = occupancy;
        a.tries    = tries_left;
`ifdef PARKING_ALM_STATS_EN
        a.acnt     = alm_count;
`else
        a.acnt     = 16'd0;
`endif
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs @%0t actual: %s required: %s", $time, fmt(a), fmt(e));
        end
      end
    end
  end

  task automatic expect_true(input bit cond, input string what);
    total++;
    if (!cond) begin
      bad++;
      $display("FAIL %s @%0t", what, $time);
    end
  endtask

  task automatic check_reset_state(input string what);
    expect_true(gate_o === 1'b0 && gate_cls === 1'b0 && alm_pin === 1'b0 &&
                alm_blkg === 1'b0 && lot_full === 1'b0 && occupancy === 8'd0 &&
                tries_left === 4'(MT), what);
`ifdef PARKING_ALM_STATS_EN
    expect_true(alm_count === 16'd0, {what, " alm_count"});
`endif
  endtask

  task automatic step(input bit r, e, x, o, pv, input int p);
    reset            = r;
    senr_e           = e;
    senr_x           = x;
    senr_out         = o;
    pin_if.pin_valid = pv;
    pin_if.pin       = 8'(p);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic enter_with_pin();
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, PV);
  endtask

  initial begin
    int         cls_seen;
    logic [7:0] occ_before;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check_reset_state("reset state");
    idle(2);

    // wrong PIN three times, then the right one clears the alarm
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 1, 5);
      step(0, 1, 0, 0, 0, 0);
    end
    step(0, 1, 0, 0, 1, 5);
    step(0, 1, 0, 0, 1, PV);
    step(0, 0, 1, 0, 0, 0);
    idle(3);

    // blocking, wrong PIN ignored in BLOCKED, correct PIN releases
    enter_with_pin();
    step(0, 1, 1, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 1, 9);
    step(0, 0, 0, 0, 1, PV);
    idle(3);

    // timeout with no senr_x
    occ_before = occupancy;
    enter_with_pin();
    cls_seen = 0;
    for (int i = 0; i < TMO + 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (gate_cls === 1'b1) cls_seen++;
    end
    expect_true(cls_seen == 1, "expired wait gate_cls pulse count");
    expect_true(occupancy === occ_before, "expired wait occupancy unchanged");
    expect_true(gate_o === 1'b0, "expired wait gate closed");

    // fill the lot, refusal, exit, simultaneous entry and exit
    for (int i = 0; i < 2; i++) begin
      enter_with_pin();
      step(0, 0, 1, 0, 0, 0);
      idle(2);
    end
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, PV);
    idle(2);
    step(0, 0, 0, 1, 0, 0);
    idle(2);
    enter_with_pin();
    step(0, 0, 1, 1, 0, 0);
    idle(2);

    // reset while blocked with three cars inside
    enter_with_pin();
    step(0, 1, 1, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 0);
    check_reset_state("mid-operation reset state");
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, e, x, o, pv;
      int p;
      r  = ($urandom_range(0, 499) == 0);
      e  = ($urandom_range(0, 2) == 0);
      x  = ($urandom_range(0, 7) == 0);
      o  = ($urandom_range(0, 9) == 0);
      pv = ($urandom_range(0, 3) == 0);
      p  = ($urandom_range(0, 1) == 0) ? PV : int'($urandom_range(0, 255));
      step(r, e, x, o, pv, p);
    end

    idle(2);
    @(negedge clock);
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
